control_stack: RTL and testbench



---
 rtl/ctl_stack_pkg.sv | 14 +
 rtl/lane_en_stack.sv | 47 ++++
 rtl/control_stack.sv | 172 +++++++++++++++++
 tb/tb_control_stack.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_stack_pkg.sv
// Shared operation encoding for the control-flow stack unit.
package ctl_stack_pkg;

    typedef logic [2:0] ctl_op_t;

    localparam ctl_op_t OP_NONE   = 3'd0;
    localparam ctl_op_t OP_CALL   = 3'd1;
    localparam ctl_op_t OP_RET    = 3'd2;
    localparam ctl_op_t OP_ALLEN  = 3'd3;
    localparam ctl_op_t OP_PUSHEN = 3'd4;
    localparam ctl_op_t OP_POPEN  = 3'd5;
    localparam ctl_op_t OP_DIS    = 3'd6;

endpackage

// File: rtl/lane_en_stack.sv
// One lane's enable (predication) stack; bit 0 is the top level.
// Push/pop qualification is decided by the parent and shared by all lanes.
module lane_en_stack #(
    parameter int EDEPTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic allen,
    input  logic dis,
    input  logic cond,
    output logic top
);

    logic [EDEPTH-1:0] stk_q;
    logic [EDEPTH-1:0] stk_d;

    // Next-state of the shift stack for the one operation active this cycle
    always_comb begin
        stk_d = stk_q;
        if (push) begin
            stk_d = {stk_q[EDEPTH-2:0], stk_q[0]};
        end else if (pop) begin
            // bottom level keeps its previous value on a pop
            stk_d = {stk_q[EDEPTH-1], stk_q[EDEPTH-1:1]};
        end else if (allen) begin
            stk_d = {stk_q[EDEPTH-1:1], 1'b1};
        end else if (dis) begin
            stk_d = {stk_q[EDEPTH-1:1], stk_q[0] & cond};
        end else begin
            stk_d = stk_q;
        end
    end

    // Stack register, every level enabled after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stk_q <= {EDEPTH{1'b1}};
        end else begin
            stk_q <= stk_d;
        end
    end

    assign top = stk_q[0];

endmodule

// File: rtl/control_stack.sv
// Return-address stack plus per-lane enable stacks with depth tracking
// and sticky overflow/underflow flags; one operation per cycle.
module control_stack
    import ctl_stack_pkg::*;
#(
    parameter int AW         = 16,
    parameter int CDEPTH     = 4,
    parameter int EDEPTH     = 32,
    parameter int LANES      = 1,
    parameter int RET_OFFSET = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid,
    input  ctl_op_t                       op,
    input  logic [AW-1:0]                 pc,
    input  logic [LANES-1:0]              lane_cond,
    output logic [AW-1:0]                 ret_addr,
    output logic [LANES-1:0]              en,
    output logic [$clog2(CDEPTH+1)-1:0]   call_depth,
    output logic [$clog2(EDEPTH)-1:0]     en_depth,
    output logic                          cs_ovf,
    output logic                          cs_unf,
    output logic                          es_ovf,
    output logic                          es_unf
);

    localparam int CW = $clog2(CDEPTH + 1);
    localparam int EW = $clog2(EDEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(CDEPTH);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [EW-1:0] E_FULL = EW'(EDEPTH - 1);
    localparam logic [EW-1:0] E_ZERO = EW'(0);
    localparam logic [EW-1:0] E_ONE  = EW'(1);

    logic [AW-1:0] cs_q [CDEPTH];
    logic [AW-1:0] cs_d [CDEPTH];
    logic [CW-1:0] call_depth_q, call_depth_d;
    logic [EW-1:0] en_depth_q, en_depth_d;
    logic          cs_ovf_q, cs_ovf_d, cs_unf_q, cs_unf_d;
    logic          es_ovf_q, es_ovf_d, es_unf_q, es_unf_d;

    logic is_call, is_ret, is_allen, is_pushen, is_popen, is_dis;
    logic lane_push, lane_pop;

    // Decode the qualified operation into one-hot strobes
    always_comb begin
        is_call   = 1'b0;
        is_ret    = 1'b0;
        is_allen  = 1'b0;
        is_pushen = 1'b0;
        is_popen  = 1'b0;
        is_dis    = 1'b0;
        if (valid) begin
            case (op)
                OP_CALL:   is_call   = 1'b1;
                OP_RET:    is_ret    = 1'b1;
                OP_ALLEN:  is_allen  = 1'b1;
                OP_PUSHEN: is_pushen = 1'b1;
                OP_POPEN:  is_popen  = 1'b1;
                OP_DIS:    is_dis    = 1'b1;
                default:   is_call   = 1'b0;
            endcase
        end else begin
            is_call = 1'b0;
        end
    end

    // Call stack, depth counters, flags and the shared push/pop decision
    always_comb begin
        cs_d         = cs_q;
        call_depth_d = call_depth_q;
        en_depth_d   = en_depth_q;
        cs_ovf_d     = cs_ovf_q;
        cs_unf_d     = cs_unf_q;
        es_ovf_d     = es_ovf_q;
        es_unf_d     = es_unf_q;
        lane_push    = 1'b0;
        lane_pop     = 1'b0;

        if (is_call) begin
            for (int i = CDEPTH - 1; i > 0; i--) begin
                cs_d[i] = cs_q[i-1];
            end
            cs_d[0] = pc;
            if (call_depth_q == C_FULL) begin
                cs_ovf_d = 1'b1;
            end else begin
                call_depth_d = call_depth_q + C_ONE;
            end
        end else if (is_ret) begin
            if (call_depth_q == C_ZERO) begin
                cs_unf_d = 1'b1;
            end else begin
                for (int i = 0; i < CDEPTH - 1; i++) begin
                    cs_d[i] = cs_q[i+1];
                end
                cs_d[CDEPTH-1] = {AW{1'b0}};
                call_depth_d   = call_depth_q - C_ONE;
            end
        end else begin
            cs_d = cs_q;
        end

        // A push at full depth still shifts: the bottom level is dropped
        if (is_pushen) begin
            lane_push = 1'b1;
            if (en_depth_q == E_FULL) begin
                es_ovf_d = 1'b1;
            end else begin
                en_depth_d = en_depth_q + E_ONE;
            end
        end else if (is_popen) begin
            if (en_depth_q == E_ZERO) begin
                es_unf_d = 1'b1;
            end else begin
                lane_pop   = 1'b1;
                en_depth_d = en_depth_q - E_ONE;
            end
        end else begin
            lane_pop = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CDEPTH; i++) begin
                cs_q[i] <= {AW{1'b0}};
            end
            call_depth_q <= C_ZERO;
            en_depth_q   <= E_ZERO;
            cs_ovf_q     <= 1'b0;
            cs_unf_q     <= 1'b0;
            es_ovf_q     <= 1'b0;
            es_unf_q     <= 1'b0;
        end else begin
            cs_q         <= cs_d;
            call_depth_q <= call_depth_d;
            en_depth_q   <= en_depth_d;
            cs_ovf_q     <= cs_ovf_d;
            cs_unf_q     <= cs_unf_d;
            es_ovf_q     <= es_ovf_d;
            es_unf_q     <= es_unf_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_en_stack #(
            .EDEPTH(EDEPTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .push  (lane_push),
            .pop   (lane_pop),
            .allen (is_allen),
            .dis   (is_dis),
            .cond  (lane_cond[l]),
            .top   (en[l])
        );
    end

    assign ret_addr   = cs_q[0] + AW'(RET_OFFSET);
    assign call_depth = call_depth_q;
    assign en_depth   = en_depth_q;
    assign cs_ovf     = cs_ovf_q;
    assign cs_unf     = cs_unf_q;
    assign es_ovf     = es_ovf_q;
    assign es_unf     = es_unf_q;

endmodule

// File: tb/tb_control_stack.sv
// Self-checking bench: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_control_stack;
    import ctl_stack_pkg::*;

    localparam int AW     = 16;
    localparam int CDEPTH = 4;
    localparam int EDEPTH = 8;
    localparam int LANES  = 4;
    localparam int OFF    = 1;
    localparam int CW     = $clog2(CDEPTH + 1);
    localparam int EW     = $clog2(EDEPTH);

    logic                clk = 1'b0;
    logic                reset;
    logic                valid;
    ctl_op_t             op;
    logic [AW-1:0]       pc;
    logic [LANES-1:0]    lane_cond;
    logic [AW-1:0]       ret_addr;
    logic [LANES-1:0]    en;
    logic [CW-1:0]       call_depth;
    logic [EW-1:0]       en_depth;
    logic                cs_ovf, cs_unf, es_ovf, es_unf;

    control_stack #(
        .AW(AW), .CDEPTH(CDEPTH), .EDEPTH(EDEPTH), .LANES(LANES), .RET_OFFSET(OFF)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .pc(pc),
        .lane_cond(lane_cond), .ret_addr(ret_addr), .en(en),
        .call_depth(call_depth), .en_depth(en_depth),
        .cs_ovf(cs_ovf), .cs_unf(cs_unf), .es_ovf(es_ovf), .es_unf(es_unf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: call stack and enable-vector stack as queues, front = top
    logic [AW-1:0]    mcs[$];
    logic [LANES-1:0] mes[$];
    logic             m_cs_ovf, m_cs_unf, m_es_ovf, m_es_unf;
    logic [AW-1:0]    ret_pre_seen;

    typedef struct {
        logic             v;
        ctl_op_t          o;
        logic [AW-1:0]    p;
        logic [LANES-1:0] c;
        logic [AW-1:0]    exp_ret;
        logic [LANES-1:0] exp_en;
        int               exp_cd;
        int               exp_ed;
        logic [3:0]       exp_flags;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    endtask

    function automatic logic [AW-1:0] m_ret();
        logic [AW-1:0] t;
        t = (mcs.size() != 0) ? mcs[0] : '0;
        return t + AW'(OFF);
    endfunction

    task automatic m_reset();
        mcs.delete();
        mes.delete();
        mes.push_back({LANES{1'b1}});
        m_cs_ovf = 1'b0; m_cs_unf = 1'b0; m_es_ovf = 1'b0; m_es_unf = 1'b0;
    endtask

    task automatic m_step(input logic v, input ctl_op_t o, input logic [AW-1:0] p,
                          input logic [LANES-1:0] c);
        logic [LANES-1:0] t;
        if (v) begin
            case (o)
                OP_CALL: begin
                    mcs.push_front(p);
                    if (mcs.size() > CDEPTH) begin
                        void'(mcs.pop_back());
                        m_cs_ovf = 1'b1;
                    end
                end
                OP_RET: begin
                    if (mcs.size() == 0) m_cs_unf = 1'b1;
                    else void'(mcs.pop_front());
                end
                OP_ALLEN: mes[0] = {LANES{1'b1}};
                OP_PUSHEN: begin
                    t = mes[0];
                    mes.push_front(t);
                    if (mes.size() > EDEPTH) begin
                        void'(mes.pop_back());
                        m_es_ovf = 1'b1;
                    end
                end
                OP_POPEN: begin
                    if (mes.size() == 1) m_es_unf = 1'b1;
                    else void'(mes.pop_front());
                end
                OP_DIS: mes[0] = mes[0] & c;
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        chk("ret_addr",   32'(ret_addr),   32'(m_ret()));
        chk("en",         32'(en),         32'(mes[0]));
        chk("call_depth", 32'(call_depth), mcs.size());
        chk("en_depth",   32'(en_depth),   mes.size() - 1);
        chk("flags", {28'd0, cs_ovf, cs_unf, es_ovf, es_unf},
            {28'd0, m_cs_ovf, m_cs_unf, m_es_ovf, m_es_unf});
    endtask

    // One cycle: drive at negedge, check same-cycle ret_addr, then post-edge state
    task automatic step(input logic v, input ctl_op_t o, input logic [AW-1:0] p,
                        input logic [LANES-1:0] c, input logic r);
        @(negedge clk);
        valid = v; op = o; pc = p; lane_cond = c; reset = r;
        #1;
        ret_pre_seen = ret_addr;
        chk("ret_pre", 32'(ret_addr), 32'(m_ret()));
        @(posedge clk);
        if (r) m_reset();
        else m_step(v, o, p, c);
        #1;
        check_model();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; op = OP_NONE; pc = '0; lane_cond = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ret",   32'(ret_addr),   32'(OFF));
        chk("rst_en",    32'(en),         32'hF);
        chk("rst_cd",    32'(call_depth), 32'd0);
        chk("rst_ed",    32'(en_depth),   32'd0);
        chk("rst_flags", {28'd0, cs_ovf, cs_unf, es_ovf, es_unf}, 32'd0);

        tbl[0]  = '{1'b1, OP_CALL,   16'h0010, 4'h0, 16'h0011, 4'hF, 1, 0, 4'h0};
        tbl[1]  = '{1'b1, OP_CALL,   16'h0020, 4'h0, 16'h0021, 4'hF, 2, 0, 4'h0};
        tbl[2]  = '{1'b1, OP_RET,    16'h0000, 4'h0, 16'h0011, 4'hF, 1, 0, 4'h0};
        tbl[3]  = '{1'b1, OP_PUSHEN, 16'h0000, 4'h0, 16'h0011, 4'hF, 1, 1, 4'h0};
        tbl[4]  = '{1'b1, OP_DIS,    16'h0000, 4'h5, 16'h0011, 4'h5, 1, 1, 4'h0};
        tbl[5]  = '{1'b1, OP_POPEN,  16'h0000, 4'h0, 16'h0011, 4'hF, 1, 0, 4'h0};
        tbl[6]  = '{1'b1, OP_DIS,    16'h0000, 4'h0, 16'h0011, 4'h0, 1, 0, 4'h0};
        tbl[7]  = '{1'b1, OP_ALLEN,  16'h0000, 4'h0, 16'h0011, 4'hF, 1, 0, 4'h0};
        tbl[8]  = '{1'b0, OP_CALL,   16'h0055, 4'h0, 16'h0011, 4'hF, 1, 0, 4'h0};
        tbl[9]  = '{1'b1, 3'd7,      16'h0066, 4'h0, 16'h0011, 4'hF, 1, 0, 4'h0};
        tbl[10] = '{1'b1, OP_RET,    16'h0000, 4'h0, 16'h0001, 4'hF, 0, 0, 4'h0};
        tbl[11] = '{1'b1, OP_PUSHEN, 16'h0000, 4'h0, 16'h0001, 4'hF, 0, 1, 4'h0};
        tbl[12] = '{1'b1, OP_DIS,    16'h0000, 4'h3, 16'h0001, 4'h3, 0, 1, 4'h0};
        tbl[13] = '{1'b1, OP_PUSHEN, 16'h0000, 4'h0, 16'h0001, 4'h3, 0, 2, 4'h0};
        tbl[14] = '{1'b1, OP_DIS,    16'h0000, 4'h1, 16'h0001, 4'h1, 0, 2, 4'h0};
        tbl[15] = '{1'b1, OP_POPEN,  16'h0000, 4'h0, 16'h0001, 4'h3, 0, 1, 4'h0};
        tbl[16] = '{1'b1, OP_POPEN,  16'h0000, 4'h0, 16'h0001, 4'hF, 0, 0, 4'h0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].o, tbl[i].p, tbl[i].c, 1'b0);
            chk("tbl_ret",   32'(ret_addr),   32'(tbl[i].exp_ret));
            chk("tbl_en",    32'(en),         32'(tbl[i].exp_en));
            chk("tbl_cd",    32'(call_depth), tbl[i].exp_cd);
            chk("tbl_ed",    32'(en_depth),   tbl[i].exp_ed);
            chk("tbl_flags", {28'd0, cs_ovf, cs_unf, es_ovf, es_unf}, 32'(tbl[i].exp_flags));
        end

        // Call-stack overflow then drain to underflow
        step(1'b0, OP_NONE, '0, '0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, OP_CALL, AW'(i), '0, 1'b0);
        chk("ovf_flag", 32'(cs_ovf), 32'd1);
        chk("ovf_cd",   32'(call_depth), 32'(CDEPTH));
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, OP_RET, '0, '0, 1'b0);
            chk("ret_seq", 32'(ret_pre_seen), 32'(7 - i));
        end
        chk("drain_cd",  32'(call_depth), 32'd0);
        chk("drain_ret", 32'(ret_addr),   32'd1);
        chk("drain_unf", 32'(cs_unf),     32'd0);
        step(1'b1, OP_RET, '0, '0, 1'b0);
        chk("unf_pre",  32'(ret_pre_seen), 32'd1);
        chk("unf_flag", 32'(cs_unf),       32'd1);
        chk("unf_ret",  32'(ret_addr),     32'd1);

        // Enable-stack underflow then overflow
        step(1'b0, OP_NONE, '0, '0, 1'b1);
        step(1'b1, OP_POPEN, '0, '0, 1'b0);
        chk("es_unf_flag", 32'(es_unf), 32'd1);
        chk("es_unf_en",   32'(en),     32'hF);
        chk("es_unf_ed",   32'(en_depth), 32'd0);
        for (int i = 0; i < EDEPTH - 1; i++) step(1'b1, OP_PUSHEN, '0, '0, 1'b0);
        chk("es_full_noovf", 32'(es_ovf),   32'd0);
        chk("es_full_ed",    32'(en_depth), 32'(EDEPTH - 1));
        step(1'b1, OP_PUSHEN, '0, '0, 1'b0);
        chk("es_ovf_flag", 32'(es_ovf),   32'd1);
        chk("es_ovf_ed",   32'(en_depth), 32'(EDEPTH - 1));

        // Reset wins over a simultaneous CALL; invalid op is ignored
        step(1'b0, OP_NONE, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, OP_CALL, AW'(16'h0100 + i), '0, 1'b0);
        chk("pre_rst_cd", 32'(call_depth), 32'd3);
        step(1'b1, OP_CALL, 16'h0777, '0, 1'b1);
        chk("rst_op_cd",    32'(call_depth), 32'd0);
        chk("rst_op_ret",   32'(ret_addr),   32'(OFF));
        chk("rst_op_flags", {28'd0, cs_ovf, cs_unf, es_ovf, es_unf}, 32'd0);
        step(1'b0, OP_CALL, 16'h0888, '0, 1'b0);
        chk("inval_cd",  32'(call_depth), 32'd0);
        chk("inval_ret", 32'(ret_addr),   32'(OFF));

        // Randomized run, lightly biased toward CALL/PUSHEN to reach the limits
        for (int n = 0; n < 3000; n++) begin
            int      sel;
            ctl_op_t ro;
            sel = $urandom_range(0, 9);
            if (sel == 8)      ro = OP_CALL;
            else if (sel == 9) ro = OP_PUSHEN;
            else               ro = ctl_op_t'(sel);
            step($urandom_range(0, 7) != 0, ro, AW'($urandom), LANES'($urandom),
                 $urandom_range(0, 149) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
